// File: rtl/simple_circuit_pipe.sv
// simple_circuit_pipe: D = (A & B) | ~C, E = ~C through a DEPTH-stage valid/ready pipeline.
// Define SIMPLE_CIRCUIT_SWEEP_EN to add the built-in 8-transaction input sweep generator.
module simple_circuit_pipe #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [W-1:0]  C,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  D,
  output logic [W-1:0]  E,
  output logic [15:0]   out_count
`ifdef SIMPLE_CIRCUIT_SWEEP_EN
  ,
  input  logic          sweep_start,
  output logic          sweep_busy
`endif
);

  logic [DEPTH-1:0] r_v;
  logic [W-1:0]     r_d [DEPTH];
  logic [W-1:0]     r_e [DEPTH];
  logic [15:0]      r_count;
  logic [DEPTH-1:0] w_rdy;
  logic             w_src_valid;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W-1:0]     w_c;

  // rdy[i] = !v[i] || rdy[i+1], unrolled as a running OR from the output end
  always_comb begin : rdy_chain
    logic w_acc;
    w_acc = out_ready;
    w_rdy = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      w_acc      = w_acc || !r_v[i-1];
      w_rdy[i-1] = w_acc;
    end
  end

`ifdef SIMPLE_CIRCUIT_SWEEP_EN
  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } sweep_state_t;

  sweep_state_t r_state;
  sweep_state_t w_state_nxt;
  logic [2:0]   r_k;
  logic [2:0]   w_k_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_src_valid = in_valid;
    w_a         = A;
    w_b         = B;
    w_c         = C;
    in_ready    = w_rdy[0];
    case (r_state)
      S_IDLE: begin
        if (sweep_start) begin
          w_state_nxt = S_SWEEP;
          w_k_nxt     = '0;
        end
      end
      S_SWEEP: begin
        w_src_valid = 1'b1;
        w_a         = {W{r_k[2]}};
        w_b         = {W{r_k[1]}};
        w_c         = {W{r_k[0]}};
        in_ready    = 1'b0;
        if (w_rdy[0]) begin
          w_k_nxt = r_k + 3'd1;
          if (r_k == 3'd7) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sweep_busy = (r_state == S_SWEEP);
`else
  assign w_src_valid = in_valid;
  assign w_a         = A;
  assign w_b         = B;
  assign w_c         = C;
  assign in_ready    = w_rdy[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
        r_e[i] <= '0;
      end
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= w_src_valid;
        r_d[0] <= (w_a & w_b) | ~w_c;
        r_e[0] <= ~w_c;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
          r_e[i] <= r_e[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_v[DEPTH-1] && out_ready && (r_count != '1)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign D         = r_d[DEPTH-1];
  assign E         = r_e[DEPTH-1];
  assign out_count = r_count;

endmodule

// File: doc/simple_circuit_pipe.md
# simple_circuit_pipe

Registered, parametrised successor to the lab's combinational `Simple_Circuit`. Computes `D = (A & B) | ~C` and `E = ~C` bitwise over `W`-bit operand vectors. Results pass through a `DEPTH`-stage valid/ready pipeline with full backpressure. Sits between a stimulus source (bench or upstream block) and a result consumer, and replaces the propagation-delay model with a clocked, cycle-exact datapath.

## Interface
Parameters:
- `W`, default 4: operand and result width in bits; legal range 1–32.
- `DEPTH`, default 2: number of pipeline register stages; legal range 1–8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `A`/`B`/`C` hold a transaction.
- `in_ready`  out  1  block accepts the transaction this cycle.
- `A`, `B`, `C`  in  W each  operand vectors.
- `out_valid`  out  1  `D`/`E` hold a result.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `D`  out  W  `(A & B) | ~C` of the transaction.
- `E`  out  W  `~C` of the transaction.
- `out_count`  out  16  number of completed output transfers; saturates at 16'hFFFF.
- `sweep_start`  in  1  present only with `SIMPLE_CIRCUIT_SWEEP_EN`.
- `sweep_busy`  out  1  present only with `SIMPLE_CIRCUIT_SWEEP_EN`.

## Operation
- Input transfer: occurs when `in_valid && in_ready`. Output transfer: occurs when `out_valid && out_ready`.
- `D` and `E` are computed combinationally from the accepted inputs and captured in stage 0. Stages 1..DEPTH-1 then carry the results unchanged.
- Each stage `i` holds a valid bit `v[i]` and W-bit `d[i]`, `e[i]`.
- Per-stage ready: `rdy[i] = !v[i] || rdy[i+1]`, with `rdy[DEPTH] = out_ready`.
- Stage `i` loads from stage `i-1` (or from the input for `i=0`) when `rdy[i]` is high.
- `in_ready = rdy[0]`. This is combinational from `out_ready` through the chain, and is permitted.
- `out_valid = v[DEPTH-1]`; `D = d[DEPTH-1]`; `E = e[DEPTH-1]`.
- Ordering: strict FIFO. No transaction is dropped or duplicated. Bubbles collapse whenever downstream stalls.
- Data values in a stage whose valid bit is 0 are don't-care. The bench checks `D`/`E` only when `out_valid` is high.
- `out_count` increments by 1 on each output transfer and holds at 16'hFFFF once reached.

## Timing
- Reset (async assert): all `v[i]`=0, all `d[i]`/`e[i]`=0, `out_valid`=0, `D`=0, `E`=0, `out_count`=0, `sweep_busy`=0.
- After reset deassertion, `in_ready`=1 in the first cycle.
- Latency: a transfer accepted at edge n appears with `out_valid`=1 after edge n+DEPTH-1, i.e. DEPTH cycles of register delay, provided there is no stall.
- Throughput: one transaction per cycle while `out_ready` stays high.
- Full pipeline with `out_ready`=0: all `v`=1, `in_ready`=0, and outputs hold stable until `out_ready` rises.
- Simultaneous accept and emit with a full pipe: legal. The pipeline shifts by one and occupancy is unchanged.
- Reset mid-stream: all in-flight results are discarded and `out_count` clears. No output transfer occurs in the reset cycle.

## Configuration
- `SIMPLE_CIRCUIT_SWEEP_EN` defined:
  - Adds ports `sweep_start` and `sweep_busy`, plus a 3-bit sweep counter `k`.
  - A `sweep_start` pulse while idle sets `sweep_busy`=1 and `k`=0. `sweep_start` is ignored while busy.
  - While busy, the block injects `A={W{k[2]}}`, `B={W{k[1]}}`, `C={W{k[0]}}` into stage 0 as its own transactions. External `in_valid` is ignored and `in_ready` is forced to 0.
  - `k` advances only when stage 0 accepts a sweep transaction. After `k`=7 is accepted, `sweep_busy` clears on that edge.
  - The sweep produces exactly 8 transactions, in order k=0..7.
- `SIMPLE_CIRCUIT_SWEEP_EN` undefined: the sweep ports and logic do not exist, and the block behaves exactly as described in Operation.

## Test plan
- W=4, DEPTH=2, `out_ready`=1. Apply A=0,B=0,C=0, then A=F,B=F,C=F, one per cycle -> results D=F,E=F then D=F,E=0, each 2 cycles after acceptance; `out_count`=2.
- Stream 16 random vectors with `out_ready`=1 -> one result per cycle, in order, each matching `(A&B)|~C` and `~C`.
- Fill the pipe with `out_ready`=0 -> `in_ready` drops after exactly DEPTH accepts. Raise `out_ready` -> DEPTH results drain in order with no duplication.
- Assert `rst` asynchronously with 2 results in flight -> `out_valid`, `D`, `E` and `out_count` read 0 immediately. No stale result emerges after release.
- Apply 65540 transfers -> `out_count`=16'hFFFF and stays there.
- With `SIMPLE_CIRCUIT_SWEEP_EN`, pulse `sweep_start` with `out_ready`=1 -> 8 results with E=F,0,F,0,F,0,F,0 and D=F,0,F,0,F,0,F,F (W=4). `sweep_busy` is high for exactly 8 accept cycles.
